// File: rtl/layer1_pkg.sv
// Shared control-word layout, default formats and saturation helper for the
// first convolution layer datapath.
package layer1_pkg;

    localparam int unsigned DEF_FRAC_BITS = 19;
    localparam int unsigned DEF_DATA_W    = 32;

    localparam int unsigned EN_W        = 10;
    localparam int unsigned EN_MASK_LSB = 0;
    localparam int unsigned EN_ACC_CLR  = 3;
    localparam int unsigned EN_Y_HOLD   = 4;
    localparam int unsigned EN_SUM_ONLY = 5;
    localparam int unsigned EN_MAC      = 6;
    localparam int unsigned EN_RELU     = 7;
    localparam int unsigned EN_ROUND    = 8;

    // Working width for saturation; must cover the widest accumulator sum.
    localparam int unsigned SAT_W = 128;

    typedef struct packed {
        logic round;
        logic relu;
        logic mac;
        logic sum_only;
        logic y_hold;
        logic acc_clr;
    } ctrl_t;

    function automatic logic signed [SAT_W-1:0] saturate(
        input  logic signed [SAT_W-1:0] t,
        input  int unsigned             w,
        output logic                    clipped
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] res;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo = ~hi;
        clipped = 1'b1;
        if (t > hi) begin
            res = hi;
        end else if (t < lo) begin
            res = lo;
        end else begin
            res = t;
            clipped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/layer1_fx_dot3.sv
// Stage 1 of the layer: masked 3-lane products registered with the control
// bits, followed by the adder tree and fixed-point rescale feeding stage 2.
module fx_dot3
    import layer1_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [EN_W-1:0]            en,
    input  logic signed [DATA_W-1:0]   x1,
    input  logic signed [DATA_W-1:0]   x2,
    input  logic signed [DATA_W-1:0]   x3,
    input  logic signed [DATA_W-1:0]   w1,
    input  logic signed [DATA_W-1:0]   w2,
    input  logic signed [DATA_W-1:0]   w3,
    output logic signed [2*DATA_W+1:0] scaled,
    output ctrl_t                      ctrl
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned SW = 2 * DATA_W + 2;

    logic signed [PW-1:0] m1, m2, m3;
    logic signed [PW-1:0] p1, p2, p3;
    logic signed [SW-1:0] s, s_rnd;
    ctrl_t                ctrl_next;
    logic                 unused_en;

    assign unused_en = en[9];

    assign m1 = PW'(x1) * PW'(w1);
    assign m2 = PW'(x2) * PW'(w2);
    assign m3 = PW'(x3) * PW'(w3);

    always_comb begin
        ctrl_next          = '0;
        ctrl_next.acc_clr  = en[EN_ACC_CLR];
        ctrl_next.y_hold   = en[EN_Y_HOLD];
        ctrl_next.sum_only = en[EN_SUM_ONLY];
        ctrl_next.mac      = en[EN_MAC];
        ctrl_next.relu     = en[EN_RELU];
        ctrl_next.round    = en[EN_ROUND];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1   <= '0;
            p2   <= '0;
            p3   <= '0;
            ctrl <= '0;
        end else begin
            p1   <= en[EN_MASK_LSB]     ? '0 : m1;
            p2   <= en[EN_MASK_LSB + 1] ? '0 : m2;
            p3   <= en[EN_MASK_LSB + 2] ? '0 : m3;
            ctrl <= ctrl_next;
        end
    end

    // Half-LSB bias before the arithmetic shift gives round-half-up.
    always_comb begin
        s      = SW'(p1) + SW'(p2) + SW'(p3);
        s_rnd  = ctrl.round ? s + (SW'(1) <<< (FRAC_BITS - 1)) : s;
        scaled = s_rnd >>> FRAC_BITS;
    end

endmodule

// File: rtl/layer1.sv
// First convolution layer: dot3 front end plus window accumulator,
// saturation, optional ReLU and the neuron output registers.
module layer1
    import layer1_pkg::*;
#(
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
    parameter int unsigned DATA_W    = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [EN_W-1:0]          en,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    input  logic signed [DATA_W-1:0] w1,
    input  logic signed [DATA_W-1:0] w2,
    input  logic signed [DATA_W-1:0] w3,
    output logic signed [DATA_W-1:0] y,
    output logic                     y_valid,
    output logic                     ovf
);

    localparam int unsigned SW = 2 * DATA_W + 2;
    localparam int unsigned TW = SW + 1;

    logic signed [SW-1:0]       scaled;
    ctrl_t                      ctrl;
    logic signed [DATA_W-1:0]   acc;
    logic signed [DATA_W-1:0]   sat_t;
    logic signed [DATA_W-1:0]   y_next;
    logic signed [TW-1:0]       base;
    logic signed [TW-1:0]       t;
    logic signed [SAT_W-1:0]    sat_wide;
    logic [SAT_W-DATA_W-1:0]    unused_sat_hi;
    logic                       clipped;

    fx_dot3 #(
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS)
    ) u_dot (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .x1    (x1),
        .x2    (x2),
        .x3    (x3),
        .w1    (w1),
        .w2    (w2),
        .w3    (w3),
        .scaled(scaled),
        .ctrl  (ctrl)
    );

    always_comb begin
        base = TW'(acc);
        if (ctrl.acc_clr) begin
            base = '0;
        end
        t = ctrl.sum_only ? TW'(scaled) : base + TW'(scaled);
        sat_wide = saturate(SAT_W'(t), DATA_W, clipped);
        {unused_sat_hi, sat_t} = sat_wide;
        y_next = (ctrl.relu && sat_t[DATA_W-1]) ? '0 : sat_t;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            y_valid <= ctrl.mac & ~ctrl.y_hold;
            if (ctrl.mac) begin
                acc <= sat_t;
                // A clipping clear-cycle leaves the flag set.
                if (clipped) begin
                    ovf <= 1'b1;
                end else if (ctrl.acc_clr) begin
                    ovf <= 1'b0;
                end
                if (!ctrl.y_hold) begin
                    y <= y_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer1.sv
// Directed self-checking bench for layer1 with hand-computed expectations.
module tb_layer1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  en;
    logic [31:0] x1, x2, x3, w1, w2, w3;
    logic [31:0] y;
    logic        y_valid;
    logic        ovf;

    int vectors = 0;
    int miscompares = 0;

    layer1 #(.FRAC_BITS(19), .DATA_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .x1     (x1),
        .x2     (x2),
        .x3     (x3),
        .w1     (w1),
        .w2     (w2),
        .w3     (w3),
        .y      (y),
        .y_valid(y_valid),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] e, input logic [31:0] xv, input logic [31:0] wv);
        en = e;
        x1 = xv; x2 = xv; x3 = xv;
        w1 = wv; w2 = wv; w3 = wv;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(10'h000, 32'h0, 32'h0);
        step;
        step;
        vectors++;
        if (y !== 32'h0) begin miscompares++; $display("FAIL reset_y got %h exp %h", y, 32'h0); end
        vectors++;
        if (y_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", y_valid); end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_scale_accum;
        drive(10'h0C8, 32'h00080000, 32'h00100000);
        step;
        drive(10'h0C0, 32'h00080000, 32'h00100000);
        step;
        vectors++;
        if (y !== 32'h00300000 || y_valid !== 1'b1) begin miscompares++; $display("FAIL scale got %h/%b exp 00300000/1", y, y_valid); end
        step;
        vectors++;
        if (y !== 32'h00600000) begin miscompares++; $display("FAIL accum1 got %h exp 00600000", y); end
        step;
        vectors++;
        if (y !== 32'h00900000) begin miscompares++; $display("FAIL accum2 got %h exp 00900000", y); end
        drive(10'h000, 32'h0, 32'h0);
        step;
        vectors++;
        if (y !== 32'h00C00000 || y_valid !== 1'b1) begin miscompares++; $display("FAIL accum3 got %h/%b exp 00C00000/1", y, y_valid); end
        step;
        vectors++;
        if (y !== 32'h00C00000 || y_valid !== 1'b0) begin miscompares++; $display("FAIL idle_hold got %h/%b exp 00C00000/0", y, y_valid); end
    endtask

    task automatic test_relu;
        drive(10'h0C8, 32'hFFF80000, 32'h00080000);
        step;
        drive(10'h048, 32'hFFF80000, 32'h00080000);
        step;
        vectors++;
        if (y !== 32'h0 || y_valid !== 1'b1) begin miscompares++; $display("FAIL relu_on got %h/%b exp 00000000/1", y, y_valid); end
        drive(10'h000, 32'h0, 32'h0);
        step;
        vectors++;
        if (y !== 32'hFFE80000) begin miscompares++; $display("FAIL relu_off got %h exp FFE80000", y); end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL relu_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_saturation;
        drive(10'h0C8, 32'h7FFFFFFF, 32'h7FFFFFFF);
        step;
        drive(10'h040, 32'hFFF80000, 32'h00080000);
        step;
        vectors++;
        if (y !== 32'h7FFFFFFF || ovf !== 1'b1) begin miscompares++; $display("FAIL sat_pos got %h/%b exp 7FFFFFFF/1", y, ovf); end
        drive(10'h0C8, 32'h00080000, 32'h00100000);
        step;
        // Accumulating down from the rail without clear keeps the sticky flag.
        vectors++;
        if (y !== 32'h7FE7FFFF || ovf !== 1'b1) begin miscompares++; $display("FAIL sat_sticky got %h/%b exp 7FE7FFFF/1", y, ovf); end
        drive(10'h048, 32'h80000000, 32'h7FFFFFFF);
        step;
        vectors++;
        if (y !== 32'h00300000 || ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %h/%b exp 00300000/0", y, ovf); end
        drive(10'h000, 32'h0, 32'h0);
        step;
        vectors++;
        if (y !== 32'h80000000 || ovf !== 1'b1) begin miscompares++; $display("FAIL sat_neg got %h/%b exp 80000000/1", y, ovf); end
    endtask

    task automatic test_mask_sum_only;
        drive(10'h0E3, 32'h00080000, 32'h00100000);
        step;
        step;
        vectors++;
        if (y !== 32'h00100000 || y_valid !== 1'b1) begin miscompares++; $display("FAIL mask0 got %h/%b exp 00100000/1", y, y_valid); end
        step;
        vectors++;
        if (y !== 32'h00100000) begin miscompares++; $display("FAIL mask1 got %h exp 00100000", y); end
        drive(10'h000, 32'h0, 32'h0);
        step;
        vectors++;
        if (y !== 32'h00100000) begin miscompares++; $display("FAIL mask2 got %h exp 00100000", y); end
    endtask

    task automatic test_y_hold;
        drive(10'h0C8, 32'h00080000, 32'h00100000);
        step;
        drive(10'h0D0, 32'h00080000, 32'h00100000);
        step;
        vectors++;
        if (y !== 32'h00300000 || ovf !== 1'b0) begin miscompares++; $display("FAIL hold_pre got %h/%b exp 00300000/0", y, ovf); end
        drive(10'h0C0, 32'h00080000, 32'h00100000);
        step;
        vectors++;
        if (y !== 32'h00300000 || y_valid !== 1'b0) begin miscompares++; $display("FAIL hold_y got %h/%b exp 00300000/0", y, y_valid); end
        drive(10'h000, 32'h0, 32'h0);
        step;
        vectors++;
        if (y !== 32'h00900000 || y_valid !== 1'b1) begin miscompares++; $display("FAIL hold_acc got %h/%b exp 00900000/1", y, y_valid); end
    endtask

    task automatic test_rounding;
        // Lane 1 only: p = +/-2^18, exactly half an output LSB.
        drive(10'h14E, 32'h00000001, 32'h00040000);
        step;
        drive(10'h04E, 32'h00000001, 32'h00040000);
        step;
        vectors++;
        if (y !== 32'h00000001) begin miscompares++; $display("FAIL round_pos got %h exp 00000001", y); end
        drive(10'h04E, 32'hFFFFFFFF, 32'h00040000);
        step;
        vectors++;
        if (y !== 32'h00000000) begin miscompares++; $display("FAIL trunc_pos got %h exp 00000000", y); end
        drive(10'h14E, 32'hFFFFFFFF, 32'h00040000);
        step;
        vectors++;
        if (y !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL trunc_neg got %h exp FFFFFFFF", y); end
        drive(10'h000, 32'h0, 32'h0);
        step;
        vectors++;
        if (y !== 32'h00000000 || y_valid !== 1'b1) begin miscompares++; $display("FAIL round_neg got %h/%b exp 00000000/1", y, y_valid); end
    endtask

    task automatic test_reset_mid;
        drive(10'h0C8, 32'h7FFFFFFF, 32'h7FFFFFFF);
        step;
        drive(10'h0C0, 32'h00080000, 32'h00100000);
        step;
        step;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (y !== 32'h0 || y_valid !== 1'b0 || ovf !== 1'b0) begin miscompares++; $display("FAIL async_rst got %h/%b/%b exp 00000000/0/0", y, y_valid, ovf); end
        step;
        #2 rst_n = 1'b1;
        step;
        vectors++;
        if (y_valid !== 1'b0 || y !== 32'h0) begin miscompares++; $display("FAIL rst_first_edge got %h/%b exp 00000000/0", y, y_valid); end
        step;
        vectors++;
        if (y !== 32'h00300000 || y_valid !== 1'b1 || ovf !== 1'b0) begin miscompares++; $display("FAIL rst_fresh got %h/%b/%b exp 00300000/1/0", y, y_valid, ovf); end
        drive(10'h000, 32'h0, 32'h0);
        step;
    endtask

    initial begin
        test_reset;
        test_scale_accum;
        test_relu;
        test_saturation;
        test_mask_sum_only;
        test_y_hold;
        test_rounding;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
